tile_ram_arbiter: RTL and testbench

Shares the single-port tile RAM (`RAM_sync`) between the tile renderer and a CPU/host port. The renderer has absolute priority and sees zero added latency. CPU writes are posted into a small FIFO and drained into idle RAM cycles. CPU reads are ordered behind all buffered writes. Sits between `tile_renderer`/`RAM_sync` and the host bus in the tile-render top level, driving the RAM `din`/`we` ports.

---
 rtl/tile_ram_arb_pkg.sv | 27 ++
 rtl/tile_ram_arb_wfifo.sv | 52 +++++
 rtl/tile_ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_tile_ram_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_ram_arb_pkg.sv
// Shared types for the tile RAM arbiter: FSM state encoding, default
// widths, the posted-write FIFO entry layout and a saturating increment.
package tile_ram_arb_pkg;

   localparam int ADDR_W_DEF      = 16;
   localparam int DATA_W_DEF      = 16;
   localparam int WFIFO_DEPTH_DEF = 4;
   localparam int STALL_W         = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RD_WAIT  = 2'd2
   } arb_state_e;

   // One buffered CPU write, address in the upper field.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wfifo_entry_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/tile_ram_arb_wfifo.sv
// Posted-write FIFO for the tile RAM arbiter. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a count. The head entry
// is presented combinationally so a pop can drive the RAM in the same cycle.
module tile_ram_arb_wfifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

   // Storage write; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
      end
   end

   // Pointer advance; reset empties the FIFO and discards buffered writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Tile RAM arbiter: the renderer owns the single-port RAM whenever vid_busy
// is high; CPU writes are posted into a small FIFO and drained into idle
// cycles, CPU reads wait for the FIFO to empty and then take three cycles.
// Optional stall counter enabled by defining TILE_RAM_ARB_STATS_EN.
module tile_ram_arbiter
   import tile_ram_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WFIFO_DEPTH = WFIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_busy,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata
`ifdef TILE_RAM_ARB_STATS_EN
  ,output logic [STALL_W-1:0] stall_cnt
`endif
);

   arb_state_e               r_state;
   arb_state_e               w_state_next;
   logic [ADDR_W-1:0]        r_rd_addr;
   logic [DATA_W-1:0]        r_rdata;
   logic                     r_rvalid;

   logic                     w_full;
   logic                     w_empty;
   logic                     w_gnt;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_rd_accept;
   logic                     w_issue;
   logic [ADDR_W+DATA_W-1:0] w_head;

   // Grant is gated by reset so nothing is accepted while reset is held.
   // Full/empty are the pre-pop values, so a full FIFO refuses a write even
   // in the cycle it drains an entry.
   assign w_gnt       = reset & cpu_req & (r_state == IDLE) &
                        (cpu_we ? ~w_full : w_empty);
   assign w_push      = w_gnt & cpu_we;
   assign w_rd_accept = w_gnt & ~cpu_we;
   assign w_pop       = ~vid_busy & ~w_empty & (r_state == IDLE);
   assign w_issue     = ~vid_busy & (r_state == RD_ISSUE);

   assign cpu_gnt    = w_gnt;
   assign cpu_rvalid = r_rvalid;
   assign cpu_rdata  = r_rdata;

   tile_ram_arb_wfifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (WFIFO_DEPTH)
   ) u_wfifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data ({cpu_addr, cpu_wdata}),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   // RAM port mux: renderer first, then a write drain, then a read issue.
   always_comb begin
      ram_addr = '0;
      ram_din  = '0;
      ram_we   = 1'b0;
      if (vid_busy) begin
         ram_addr = vid_addr;
      end else if (w_pop) begin
         {ram_addr, ram_din} = w_head;
         ram_we              = 1'b1;
      end else if (w_issue) begin
         ram_addr = r_rd_addr;
      end
   end

   // Read sequencing; RD_WAIT never waits on the renderer because the data
   // was already addressed in the previous cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (w_rd_accept) w_state_next = RD_ISSUE;
         RD_ISSUE: if (!vid_busy)   w_state_next = RD_WAIT;
         RD_WAIT:                   w_state_next = IDLE;
         default:                   w_state_next = IDLE;
      endcase
   end

   // State, read address latch and read-return registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_rd_addr <= '0;
         r_rdata   <= '0;
         r_rvalid  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_rvalid <= (r_state == RD_WAIT);
         if (w_rd_accept) begin
            r_rd_addr <= cpu_addr;
         end
         if (r_state == RD_WAIT) begin
            r_rdata <= ram_dout;
         end
      end
   end

`ifdef TILE_RAM_ARB_STATS_EN
   logic [STALL_W-1:0] r_stall_cnt;
   logic               w_stall;

   // CPU has work the renderer is holding off: pending writes or a read issue.
   assign w_stall   = vid_busy & (((r_state == IDLE) & ~w_empty) | (r_state == RD_ISSUE));
   assign stall_cnt = r_stall_cnt;

   // Saturating stall counter, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end
`else
   // Statistics disabled: no stall counter is built.
`endif

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench for tile_ram_arbiter with a behavioural synchronous RAM.
// Expected RAM writes and read data are queued as stimulus is driven and
// popped when the DUT asserts ram_we / cpu_rvalid.
module tb_tile_ram_arbiter;
   import tile_ram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        vid_busy;
   logic [15:0] vid_addr;
   logic [15:0] ram_addr;
   logic [15:0] ram_din;
   logic        ram_we;
   logic [15:0] ram_dout;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_rvalid;
   logic [15:0] cpu_rdata;
`ifdef TILE_RAM_ARB_STATS_EN
   logic [15:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   wfifo_entry_t wr_q[$];
   logic [15:0]  rd_q[$];
   logic [15:0]  ram_mem [65536];

   always #5 clk = ~clk;

   tile_ram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .vid_busy   (vid_busy),
      .vid_addr   (vid_addr),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_we     (ram_we),
      .ram_dout   (ram_dout),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata)
`ifdef TILE_RAM_ARB_STATS_EN
     ,.stall_cnt  (stall_cnt)
`endif
   );

   // Synchronous single-port RAM, read-before-write.
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard and renderer-ownership checks for the current cycle.
   task automatic monitor();
      wfifo_entry_t e;
      if (reset) begin
         if (vid_busy) begin
            chk("vid_we_low", {31'd0, ram_we}, 32'd0);
            chk("vid_addr_pass", {16'd0, ram_addr}, {16'd0, vid_addr});
         end
         if (ram_we) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_ram_we", {31'd0, ram_we}, 32'd0);
            end else begin
               e = wr_q.pop_front();
               chk("wr_addr", {16'd0, ram_addr}, {16'd0, e.addr});
               chk("wr_data", {16'd0, ram_din}, {16'd0, e.data});
               $display("write addr=%h data=%h", ram_addr, ram_din);
            end
         end
         if (cpu_rvalid) begin
            if (rd_q.size() == 0) begin
               chk("unexpected_rvalid", {31'd0, cpu_rvalid}, 32'd0);
            end else begin
               chk("rdata", {16'd0, cpu_rdata}, {16'd0, rd_q.pop_front()});
               $display("read data=%h", cpu_rdata);
            end
         end
      end
   endtask

   task automatic settle();
      #1;
      monitor();
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   // Single write into an idle arbiter: granted at once, on the RAM next cycle.
   task automatic single_write(input logic [15:0] a, input logic [15:0] d, input string tag);
      vid_busy = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      wr_q.push_back('{addr: a, data: d});
      settle();
      chk({tag, "_gnt"}, {31'd0, cpu_gnt}, 32'd1);
      adv();
      cpu_req = 1'b0;
      settle();
      chk({tag, "_we"}, {31'd0, ram_we}, 32'd1);
      chk({tag, "_addr"}, {16'd0, ram_addr}, {16'd0, a});
      chk({tag, "_din"}, {16'd0, ram_din}, {16'd0, d});
      adv();
      settle();
      chk({tag, "_idle_we"}, {31'd0, ram_we}, 32'd0);
      chk({tag, "_idle_addr"}, {16'd0, ram_addr}, 32'd0);
      adv();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; vid_busy = 1'b0; vid_addr = '0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_wdata = 16'h4567;
      adv(); adv();

      // Reset values, with a request pending to show the grant is held off.
      settle();
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_addr", {16'd0, ram_addr}, 32'd0);
      chk("rst_din", {16'd0, ram_din}, 32'd0);
      chk("rst_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
      vid_busy = 1'b1; vid_addr = 16'h5555;
      settle();
      chk("rst_vid_addr", {16'd0, ram_addr}, 32'h5555);
      adv();
      cpu_req = 1'b0; vid_busy = 1'b0; reset = 1'b1;
      adv();

      // T1: single write.
      single_write(16'h0040, 16'h1234, "t1");

      // T2: five writes under renderer ownership; the fifth is refused.
      vid_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vid_addr = 16'h0A00 + 16'(i);
         cpu_req = 1'b1; cpu_we = 1'b1;
         cpu_addr = 16'h0200 + 16'(i); cpu_wdata = 16'hD000 + 16'(i);
         if (i < 4) wr_q.push_back('{addr: cpu_addr, data: cpu_wdata});
         settle();
         chk("t2_gnt", {31'd0, cpu_gnt}, {31'd0, (i < 4)});
         adv();
      end
      wr_q.push_back('{addr: 16'h0204, data: 16'hD004});
      for (int i = 0; i < 2; i++) begin
         vid_addr = 16'h0B00 + 16'(i);
         settle();
         chk("t2_hold_gnt", {31'd0, cpu_gnt}, 32'd0);
         adv();
      end
      vid_busy = 1'b0;
      settle();
      chk("t2_full_pop_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("t2_drain0_we", {31'd0, ram_we}, 32'd1);
      adv();
      settle();
      chk("t2_retry_gnt", {31'd0, cpu_gnt}, 32'd1);
      chk("t2_drain1_we", {31'd0, ram_we}, 32'd1);
      adv();
      cpu_req = 1'b0;
      for (int i = 2; i < 5; i++) begin
         settle();
         chk("t2_drain_we", {31'd0, ram_we}, 32'd1);
         adv();
      end
      settle();
      chk("t2_idle_we", {31'd0, ram_we}, 32'd0);
      chk("t2_drained", wr_q.size(), 32'd0);
      adv();

      // T3: read-after-write waits for the FIFO and returns the new data.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
      wr_q.push_back('{addr: 16'h0100, data: 16'hBEEF});
      settle();
      chk("t3_wr_gnt", {31'd0, cpu_gnt}, 32'd1);
      adv();
      cpu_we = 1'b0;
      rd_q.push_back(16'hBEEF);
      settle();
      chk("t3_rd_blocked", {31'd0, cpu_gnt}, 32'd0);
      chk("t3_drain_we", {31'd0, ram_we}, 32'd1);
      adv();
      settle();
      chk("t3_rd_gnt", {31'd0, cpu_gnt}, 32'd1);
      adv();
      cpu_req = 1'b0;
      settle();
      chk("t3_issue_addr", {16'd0, ram_addr}, 32'h0100);
      chk("t3_issue_we", {31'd0, ram_we}, 32'd0);
      chk("t3_rvalid_n1", {31'd0, cpu_rvalid}, 32'd0);
      adv();
      settle();
      chk("t3_rvalid_n2", {31'd0, cpu_rvalid}, 32'd0);
      adv();
      settle();
      chk("t3_rvalid_n3", {31'd0, cpu_rvalid}, 32'd1);
      chk("t3_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
      adv();
      settle();
      chk("t3_rvalid_pulse", {31'd0, cpu_rvalid}, 32'd0);
      adv();

      // T4: read delayed by three renderer cycles; renderer activity in
      // RD_WAIT points the RAM at 0x0040 (0x1234) and must not leak in.
      single_write(16'h0010, 16'h00AA, "t4w");
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      rd_q.push_back(16'h00AA);
      settle();
      chk("t4_gnt", {31'd0, cpu_gnt}, 32'd1);
      adv();
      cpu_req = 1'b0;
      vid_busy = 1'b1; vid_addr = 16'h0777;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t4_wait_rvalid", {31'd0, cpu_rvalid}, 32'd0);
         adv();
      end
      vid_busy = 1'b0;
      settle();
      chk("t4_issue_addr", {16'd0, ram_addr}, 32'h0010);
      adv();
      vid_busy = 1'b1; vid_addr = 16'h0040;
      settle();
      chk("t4_rdwait_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      adv();
      vid_busy = 1'b0;
      settle();
      chk("t4_rvalid_n6", {31'd0, cpu_rvalid}, 32'd1);
      chk("t4_rdata", {16'd0, cpu_rdata}, 32'h00AA);
      adv();
      vid_busy = 1'b1; vid_addr = 16'h0200;
      settle();
      chk("t4_rvalid_low", {31'd0, cpu_rvalid}, 32'd0);
      chk("t4_rdata_held", {16'd0, cpu_rdata}, 32'h00AA);
      adv();

      // T5a: reset discards two buffered writes.
      vid_addr = 16'h0999;
      for (int i = 0; i < 2; i++) begin
         cpu_req = 1'b1; cpu_we = 1'b1;
         cpu_addr = 16'h0300 + 16'(i); cpu_wdata = 16'hC000 + 16'(i);
         wr_q.push_back('{addr: cpu_addr, data: cpu_wdata});
         settle();
         chk("t5_buf_gnt", {31'd0, cpu_gnt}, 32'd1);
         adv();
      end
      cpu_req = 1'b0;
      reset = 1'b0;
      wr_q.delete();
      settle();
      chk("t5_rst_we", {31'd0, ram_we}, 32'd0);
      chk("t5_rst_addr", {16'd0, ram_addr}, 32'h0999);
      chk("t5_rst_din", {16'd0, ram_din}, 32'd0);
      adv();
      reset = 1'b1; vid_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t5_no_we", {31'd0, ram_we}, 32'd0);
         adv();
      end

      // T5b: reset while the read is stuck in RD_ISSUE aborts it.
      vid_busy = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      settle();
      chk("t5_rd_gnt", {31'd0, cpu_gnt}, 32'd1);
      adv();
      cpu_req = 1'b0;
      settle();
      adv();
      reset = 1'b0;
      settle();
      chk("t5_rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("t5_rst_rdata", {16'd0, cpu_rdata}, 32'd0);
      chk("t5_rst_gnt", {31'd0, cpu_gnt}, 32'd0);
      adv();
      reset = 1'b1; vid_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t5_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
         chk("t5_no_we2", {31'd0, ram_we}, 32'd0);
         adv();
      end
      single_write(16'h0040, 16'h1234, "t5w");

`ifdef TILE_RAM_ARB_STATS_EN
      // Stall counter: clear, then two writes held off by the renderer.
      reset = 1'b0;
      settle();
      chk("st_rst", {16'd0, stall_cnt}, 32'd0);
      adv();
      reset = 1'b1;
      vid_busy = 1'b1; vid_addr = 16'h0321;
      for (int i = 0; i < 2; i++) begin
         cpu_req = 1'b1; cpu_we = 1'b1;
         cpu_addr = 16'h0400 + 16'(i); cpu_wdata = 16'hE000 + 16'(i);
         wr_q.push_back('{addr: cpu_addr, data: cpu_wdata});
         settle();
         chk("st_wr_gnt", {31'd0, cpu_gnt}, 32'd1);
         adv();
      end
      cpu_req = 1'b0;
      settle();
      chk("st_after_b", {16'd0, stall_cnt}, 32'd1);
      // Ten more blocked cycles with both writes pending, on top of the one
      // counted while the second write was being accepted.
      for (int i = 0; i < 10; i++) begin
         settle();
         adv();
      end
      settle();
      chk("st_ten_more", {16'd0, stall_cnt}, 32'd11);
      vid_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         adv();
      end
      settle();
      chk("st_no_count_free", {16'd0, stall_cnt}, 32'd11);
      // Saturation: a read parked in RD_ISSUE for more than 65535 cycles.
      vid_busy = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      settle();
      chk("st_rd_gnt", {31'd0, cpu_gnt}, 32'd1);
      adv();
      cpu_req = 1'b0;
      for (int i = 0; i < 65540; i++) adv();
      settle();
      chk("st_saturate", {16'd0, stall_cnt}, 32'hFFFF);
      adv();
      settle();
      chk("st_sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
      reset = 1'b0;
      #1;
      chk("st_clear", {16'd0, stall_cnt}, 32'd0);
      adv();
      reset = 1'b1; vid_busy = 1'b0;
      adv();
`endif

      chk("final_wr_q_empty", wr_q.size(), 32'd0);
      chk("final_rd_q_empty", rd_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
